// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: pipeline-side hazard inputs and hazard-unit control outputs
interface pipeline_hazard_unit_if #(parameter int CNT_W = 16);
   logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
   logic             if_id_rs1_used, if_id_rs2_used;
   logic             id_ex_mem_read, ex_branch_taken, ex_muldiv_start, ex_muldiv_done;
   logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_flush;
   logic [1:0]       state;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_cycles;
   modport master (
      output if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used, id_ex_rd, id_ex_mem_read,
             ex_branch_taken, ex_muldiv_start, ex_muldiv_done,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_flush,
             state, md_timeout, stall_cycles
   );
   modport slave (
      input  if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used, id_ex_rd, id_ex_mem_read,
             ex_branch_taken, ex_muldiv_start, ex_muldiv_done,
      output pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_flush,
             state, md_timeout, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: load-use, taken-branch and multi-cycle mul/div hazard control
module pipeline_hazard_unit #(
   parameter int MD_TIMEOUT = 63,
   parameter int CNT_W      = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_unit_if.slave hz
);
   typedef enum logic [1:0] {RUN = 2'b00, MD_WAIT = 2'b01} state_t;
   state_t           r_state, w_next;
   logic [5:0]       r_wait, w_wait_next;
   logic             r_timeout;
   logic [CNT_W-1:0] r_stalls;
   logic             w_lu, w_lu_stall, w_br_flush, w_md_stall, w_hit, w_stall;
   assign w_lu = hz.id_ex_mem_read && hz.id_ex_rd != 5'd0 &&
                 ((hz.if_id_rs1_used && hz.if_id_rs1 == hz.id_ex_rd) ||
                  (hz.if_id_rs2_used && hz.if_id_rs2 == hz.id_ex_rd));
   always_comb begin
      w_next      = r_state;
      w_wait_next = r_wait;
      w_br_flush  = 1'b0;
      w_lu_stall  = 1'b0;
      w_md_stall  = 1'b0;
      if (r_state == RUN) begin
         w_br_flush = hz.ex_branch_taken;
         w_lu_stall = !hz.ex_branch_taken && w_lu;
         if (!hz.ex_branch_taken && hz.ex_muldiv_start) begin
            w_wait_next = 6'd0;
            w_next      = hz.ex_muldiv_done ? RUN : MD_WAIT;
         end
      end else begin
         w_md_stall = !hz.ex_muldiv_done;
         w_next     = hz.ex_muldiv_done ? RUN : MD_WAIT;
         if (!hz.ex_muldiv_done && r_wait != 6'd63) w_wait_next = r_wait + 6'd1;
      end
   end
   // timeout is visible in the cycle the limit is reached, then held by r_timeout
   assign w_hit   = w_md_stall && r_wait == 6'(MD_TIMEOUT);
   assign w_stall = !rst && (w_lu_stall || w_md_stall);
   assign hz.pc_stall     = w_stall;
   assign hz.if_id_stall  = w_stall;
   assign hz.id_ex_stall  = !rst && w_md_stall;
   assign hz.ex_mem_flush = !rst && w_md_stall;
   assign hz.if_id_flush  = rst || w_br_flush;
   assign hz.id_ex_flush  = rst || w_br_flush || w_lu_stall;
   assign hz.state        = r_state;
   assign hz.md_timeout   = !rst && (r_timeout || w_hit);
   assign hz.stall_cycles = r_stalls;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RUN;
         r_wait    <= 6'd0;
         r_timeout <= 1'b0;
         r_stalls  <= '0;
      end else begin
         r_state   <= w_next;
         r_wait    <= w_wait_next;
         r_timeout <= r_timeout || w_hit;
         if (w_stall && r_stalls != '1) r_stalls <= r_stalls + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: two configurations against a queued reference model
module tb_pipeline_hazard_unit;
   logic clk, rst;
   pipeline_hazard_unit_if #(.CNT_W(16)) if_a ();
   pipeline_hazard_unit_if #(.CNT_W(4))  if_b ();
   pipeline_hazard_unit #(.MD_TIMEOUT(63), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .hz(if_a.slave));
   pipeline_hazard_unit #(.MD_TIMEOUT(3),  .CNT_W(4))  u_b (.clk(clk), .rst(rst), .hz(if_b.slave));
   typedef struct {logic [8:0] ctl; int cnt;} exp_t;
   exp_t q0[$], q1[$];
   int checks = 0, errors = 0, cyc = 0;
   int lim[2] = '{63, 3};
   int wid[2] = '{16, 4};
   bit m_wait[2], m_tout[2];
   int m_waits[2], m_stalls[2];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(string nm, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (q0.size() > 0 && q1.size() > 0) begin
         exp_t e0, e1;
         e0 = q0.pop_front();
         e1 = q1.pop_front();
         chk("ctl_a", int'({if_a.pc_stall, if_a.if_id_stall, if_a.if_id_flush, if_a.id_ex_flush,
                            if_a.id_ex_stall, if_a.ex_mem_flush, if_a.state, if_a.md_timeout}), int'(e0.ctl));
         chk("cnt_a", int'(if_a.stall_cycles), e0.cnt);
         chk("ctl_b", int'({if_b.pc_stall, if_b.if_id_stall, if_b.if_id_flush, if_b.id_ex_flush,
                            if_b.id_ex_stall, if_b.ex_mem_flush, if_b.state, if_b.md_timeout}), int'(e1.ctl));
         chk("cnt_b", int'(if_b.stall_cycles), e1.cnt);
         cyc++;
      end
   end
   task automatic drive(bit r, bit mr, bit [4:0] rd, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                        bit br, bit st, bit dn);
      rst = r;
      if_a.id_ex_mem_read = mr;  if_b.id_ex_mem_read = mr;
      if_a.id_ex_rd = rd;        if_b.id_ex_rd = rd;
      if_a.if_id_rs1 = rs1;      if_b.if_id_rs1 = rs1;
      if_a.if_id_rs1_used = u1;  if_b.if_id_rs1_used = u1;
      if_a.if_id_rs2 = rs2;      if_b.if_id_rs2 = rs2;
      if_a.if_id_rs2_used = u2;  if_b.if_id_rs2_used = u2;
      if_a.ex_branch_taken = br; if_b.ex_branch_taken = br;
      if_a.ex_muldiv_start = st; if_b.ex_muldiv_start = st;
      if_a.ex_muldiv_done = dn;  if_b.ex_muldiv_done = dn;
   endtask
   task automatic step(bit r, bit mr, bit [4:0] rd, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                       bit br, bit st, bit dn);
      bit lu;
      drive(r, mr, rd, rs1, u1, rs2, u2, br, st, dn);
      lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      for (int k = 0; k < 2; k++) begin
         bit ps = 0, f1 = 0, f2 = 0, es = 0, to = 0;
         exp_t e;
         int cap = (1 << wid[k]) - 1;
         if (r) begin
            f1 = 1; f2 = 1;
         end else if (!m_wait[k]) begin
            if (br) begin f1 = 1; f2 = 1; end
            else if (lu) begin ps = 1; f2 = 1; end
            to = m_tout[k];
         end else begin
            if (!dn) begin ps = 1; es = 1; end
            to = m_tout[k] || (!dn && m_waits[k] == lim[k]);
         end
         e.ctl = {ps, ps, f1, f2, es, es, m_wait[k] ? 2'b01 : 2'b00, to};
         e.cnt = m_stalls[k] < cap ? m_stalls[k] : cap;
         if (k == 0) q0.push_back(e); else q1.push_back(e);
         if (r) begin
            m_wait[k] = 0; m_waits[k] = 0; m_tout[k] = 0; m_stalls[k] = 0;
         end else begin
            m_stalls[k] += int'(ps);
            m_tout[k] = to;
            if (!m_wait[k]) begin
               if (!br && st && !dn) begin m_wait[k] = 1; m_waits[k] = 0; end
            end else if (dn) m_wait[k] = 0;
            else if (m_waits[k] < 63) m_waits[k]++;
         end
      end
      @(posedge clk); #1;
   endtask
   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic reset1();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset1();
      idle(1);
      step(0, 1, 5, 0, 0, 5, 1, 0, 0, 0);
      idle(1);
      step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 7, 7, 0, 3, 1, 0, 0, 0);
      step(0, 1, 9, 9, 1, 0, 0, 1, 0, 0);
      reset1();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 1, 4, 4, 1, 0, 0, 0, 1, 0);
      step(0, 1, 4, 4, 1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      reset1();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 70; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      reset1();
      idle(1);
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) == 0);
      idle(2);
      @(negedge clk); @(negedge clk);
      chk("queue_drained", q0.size() + q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
